pat_velocity_rx: RTL and testbench
==================================

# pat_velocity_rx

Receives motion packets from the 52 MCU (accelerometer-derived paddle velocity) through an already-decoded UART byte stream. Converts each packet into the sign-magnitude velocity word and direction bits consumed by the paddle position update stage, and issues its once-per-frame update strobe. Sits directly upstream of the paddle location updater in the pingpong_v2 pat path.

## Interface
- HEADER, 8'hA5, packet start byte
- DEADZONE, 16'd8, magnitudes below this value are forced to 0
- BYTE_TIMEOUT, 50000, clocks allowed between bytes of one packet before the packet is aborted
- LINK_TIMEOUT, 8, frame_ticks without a good packet before the link is declared lost
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe qualifying rx_data
- frame_tick  in  1  one-cycle strobe per video frame
- pat_velocity  out  32  {1'b0, |vx|[14:0], 1'b0, |vy|[14:0]}, 4 fractional bits per field
- direction_x  out  1  1 = +x (vx ≥ 0)
- direction_y  out  1  1 = paddle moves up, i.e. y decreases (vy > 0)
- Update_pat  out  1  one-cycle update strobe to the location stage
- pkt_err  out  1  one-cycle pulse on checksum failure or byte timeout
- link_ok  out  1  a good packet was received within the last LINK_TIMEOUT frames

## Operation
- Packet format: HEADER, vx_hi, vx_lo, vy_hi, vy_lo, chk. vx and vy are 16-bit two's complement. chk = XOR of the 4 payload bytes.
- FSM states: IDLE → VX_H → VX_L → VY_H → VY_L → CHK → IDLE. The FSM advances only on rx_valid.
  - In IDLE, non-HEADER bytes are discarded.
  - A HEADER byte that arrives mid-packet is treated as data; no resync.
- CHK byte handling:
  - On match, the packet commits: pat_velocity, direction_x, direction_y and link_ok are updated, and the frame-age counter clears.
  - On mismatch, pkt_err pulses and all outputs are held.
- Byte timeout: a clock counter clears on every rx_valid. If it reaches BYTE_TIMEOUT in any non-IDLE state, the FSM returns to IDLE and pkt_err pulses. The partial payload is discarded.
- Magnitude rules:
  - |v| is computed in 16 bits and saturated to 15 bits, so 0x8000 gives 0x7FFF.
  - If |v| < DEADZONE, the magnitude is forced to 0.
  - Bit 15 of each field is always 0.
- Direction rules:
  - direction_x = ~vx[15].
  - direction_y = (vy > 0).
  - A magnitude of 0 still sets the direction from the sign.
- Link timeout:
  - The frame-age counter increments on each frame_tick and saturates at LINK_TIMEOUT.
  - On reaching LINK_TIMEOUT: link_ok=0, pat_velocity=0, and the directions are held.
- Update_pat is asserted the cycle after frame_tick only if link_ok=1 at the time of the tick.

## Timing
- Reset values:
  - pat_velocity = 0
  - direction_x = 1
  - direction_y = 0
  - Update_pat = 0
  - pkt_err = 0
  - link_ok = 0
  - FSM = IDLE; all counters 0
- Commit latency: new pat_velocity, directions and link_ok are visible 1 cycle after the rx_valid cycle of chk.
- pkt_err is visible 1 cycle after the failing chk byte or the timeout cycle.
- Update_pat is high for exactly 1 cycle, 1 cycle after frame_tick. pat_velocity and the directions are stable while Update_pat is high.
- Commit and frame_tick in the same cycle: Update_pat fires the next cycle, carrying the newly committed velocity.
  - link_ok is evaluated pre-commit. The first-ever good packet therefore does not produce an Update_pat on a coincident tick.
- Commit and link timeout in the same cycle: the commit wins (link_ok=1, age=0).
- rst_n asserted mid-packet: the FSM returns to IDLE immediately and the partial packet is lost.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package pingpong_pkg holds:
  - the FSM state enum
  - the HEADER default
  - the field slices (X_FIELD = 31:16, Y_FIELD = 15:0, 4 fractional bits)
  - the location field positions reused by the location stage
- Sub-module vel_abs_sat converts a 16-bit signed value into a sign bit plus a 15-bit saturated, deadzoned magnitude. It is purely combinational and instantiated twice (x and y).
- The top level contains the FSM, payload shift registers, XOR accumulator, byte-timeout counter, frame-age counter and output registers.

## Test plan
- Bytes A5 01 20 FF 00 DE → pat_velocity=32'h0120_0100, direction_x=1, direction_y=0, link_ok=1. The next frame_tick yields a 1-cycle Update_pat.
- Bytes A5 80 00 00 05 85 → x field=16'h7FFF, direction_x=0; y field=0 because 5 < DEADZONE; direction_y=1.
- Same packet as the first case but chk=00 → pkt_err pulse; pat_velocity unchanged; FSM back in IDLE.
- A5 01 followed by a 50000-clock gap → pkt_err pulse. A complete valid packet sent afterwards commits normally.
- Valid packet, then 8 frame_ticks with no traffic → link_ok=0, pat_velocity=0, and no Update_pat from the 8th tick onward.
- Good chk byte coincident with frame_tick while link_ok=1 → Update_pat next cycle with the new velocity. Assert rst_n mid-packet → all outputs at reset values and FSM in IDLE.

Source files
------------

// File: rtl/pingpong_pkg.sv
// Shared definitions for the pingpong_v2 paddle (pat) path.
// Holds the motion-packet receiver state enum, the default packet header,
// the velocity word field layout and the location-word field positions
// used by the downstream location stage.
package pingpong_pkg;

    // Default packet start byte from the motion MCU
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Velocity word layout: X_FIELD = 31:16, Y_FIELD = 15:0
    localparam int unsigned FIELD_W     = 16;
    localparam int unsigned MAG_W       = 15;
    localparam int unsigned FRAC_BITS   = 4;
    localparam int unsigned X_FIELD_MSB = 31;
    localparam int unsigned X_FIELD_LSB = 16;
    localparam int unsigned Y_FIELD_MSB = 15;
    localparam int unsigned Y_FIELD_LSB = 0;

    // Location word field positions, same split as the velocity word
    localparam int unsigned LOC_X_MSB = 31;
    localparam int unsigned LOC_X_LSB = 16;
    localparam int unsigned LOC_Y_MSB = 15;
    localparam int unsigned LOC_Y_LSB = 0;

    // Packet receiver FSM states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        VX_H = 3'd1,
        VX_L = 3'd2,
        VY_H = 3'd3,
        VY_L = 3'd4,
        CHK  = 3'd5
    } rx_state_e;

    // Sign-magnitude velocity word; the reserved bits are always zero
    typedef struct packed {
        logic             x_rsvd;
        logic [MAG_W-1:0] x_mag;
        logic             y_rsvd;
        logic [MAG_W-1:0] y_mag;
    } vel_word_t;

endpackage

// File: rtl/vel_abs_sat.sv
// Signed 16-bit velocity to sign + 15-bit saturated, deadzoned magnitude.
// Purely combinational; one instance per axis.
//   v      : 16-bit two's-complement velocity
//   sign_c : v[15]
//   mag_c  : |v| saturated to 15 bits, forced to 0 below DEADZONE
module vel_abs_sat
    import pingpong_pkg::*;
#(
    parameter logic [15:0] DEADZONE = 16'd8
) (
    input  logic [FIELD_W-1:0] v,
    output logic               sign_c,
    output logic [MAG_W-1:0]   mag_c
);

    logic [FIELD_W-1:0] abs_c;

    // Only 0x8000 has bit 15 set after negation; clamp it to 0x7FFF
    always_comb begin
        sign_c = v[FIELD_W-1];
        abs_c  = v[FIELD_W-1] ? (~v + FIELD_W'(1)) : v;
        mag_c  = abs_c[FIELD_W-1] ? {MAG_W{1'b1}} : abs_c[MAG_W-1:0];
        if ({1'b0, mag_c} < DEADZONE) begin
            mag_c = '0;
        end
    end

endmodule

// File: rtl/pat_velocity_rx.sv
// Motion packet receiver for the paddle (pat) path.
// Parses HEADER, vx_hi, vx_lo, vy_hi, vy_lo, chk from the decoded UART byte
// stream, converts a checksum-clean packet into the sign-magnitude velocity
// word plus direction bits, and issues the per-frame update strobe while the
// link is alive.
//   clk, rst_n   : clock, async active-low reset
//   rx_data      : received byte, qualified by rx_valid
//   frame_tick   : one-cycle strobe per video frame
//   pat_velocity : {0, |vx|[14:0], 0, |vy|[14:0]}, 4 fractional bits/field
//   direction_x  : 1 when vx >= 0
//   direction_y  : 1 when vy > 0 (paddle moves up)
//   Update_pat   : one-cycle strobe the cycle after an accepted frame_tick
//   pkt_err      : one-cycle pulse on checksum failure or byte timeout
//   link_ok      : good packet seen within the last LINK_TIMEOUT frames
module pat_velocity_rx
    import pingpong_pkg::*;
#(
    parameter logic [7:0]  HEADER       = HEADER_DEFAULT,
    parameter logic [15:0] DEADZONE     = 16'd8,
    parameter int unsigned BYTE_TIMEOUT = 50000,
    parameter int unsigned LINK_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        frame_tick,
    output logic [31:0] pat_velocity,
    output logic        direction_x,
    output logic        direction_y,
    output logic        Update_pat,
    output logic        pkt_err,
    output logic        link_ok
);

    localparam int unsigned TO_W  = $clog2(BYTE_TIMEOUT + 1);
    localparam int unsigned AGE_W = $clog2(LINK_TIMEOUT + 1);

    rx_state_e          state, state_nxt;
    logic [FIELD_W-1:0] vx_q, vy_q;
    logic [7:0]         chk_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [AGE_W-1:0]   age_q;
    vel_word_t          vel_q;

    logic               commit_c, bad_chk_c, timeout_c, expire_c;
    logic               sx_c, sy_c;
    logic [MAG_W-1:0]   mx_c, my_c;

    vel_abs_sat #(.DEADZONE(DEADZONE)) u_abs_x (
        .v      (vx_q),
        .sign_c (sx_c),
        .mag_c  (mx_c)
    );

    vel_abs_sat #(.DEADZONE(DEADZONE)) u_abs_y (
        .v      (vy_q),
        .sign_c (sy_c),
        .mag_c  (my_c)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle events; a byte arriving wins over a timeout
    always_comb begin
        state_nxt = state;
        commit_c  = 1'b0;
        bad_chk_c = 1'b0;
        timeout_c = 1'b0;
        expire_c  = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: if (rx_data == HEADER) state_nxt = VX_H;
                VX_H: state_nxt = VX_L;
                VX_L: state_nxt = VY_H;
                VY_H: state_nxt = VY_L;
                VY_L: state_nxt = CHK;
                CHK: begin
                    state_nxt = IDLE;
                    if (rx_data == chk_q) begin
                        commit_c = 1'b1;
                    end else begin
                        bad_chk_c = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && to_cnt_q == TO_W'(BYTE_TIMEOUT)) begin
            timeout_c = 1'b1;
            state_nxt = IDLE;
        end
        // A commit in the same cycle keeps the link alive
        if (frame_tick && !commit_c && age_q == AGE_W'(LINK_TIMEOUT - 1)) begin
            expire_c = 1'b1;
        end
    end

    // Payload shift registers and running XOR of payload bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vx_q  <= '0;
            vy_q  <= '0;
            chk_q <= '0;
        end else if (rx_valid) begin
            case (state)
                VX_H: begin
                    vx_q[15:8] <= rx_data;
                    chk_q      <= rx_data;
                end
                VX_L: begin
                    vx_q[7:0] <= rx_data;
                    chk_q     <= chk_q ^ rx_data;
                end
                VY_H: begin
                    vy_q[15:8] <= rx_data;
                    chk_q      <= chk_q ^ rx_data;
                end
                VY_L: begin
                    vy_q[7:0] <= rx_data;
                    chk_q     <= chk_q ^ rx_data;
                end
                default: ;
            endcase
        end
    end

    // Inter-byte gap counter, only running while inside a packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (rx_valid || state == IDLE) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != TO_W'(BYTE_TIMEOUT)) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // Frames since the last good packet, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else if (commit_c) begin
            age_q <= '0;
        end else if (frame_tick && age_q != AGE_W'(LINK_TIMEOUT)) begin
            age_q <= age_q + AGE_W'(1);
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vel_q       <= '0;
            direction_x <= 1'b1;
            direction_y <= 1'b0;
            Update_pat  <= 1'b0;
            pkt_err     <= 1'b0;
            link_ok     <= 1'b0;
        end else begin
            pkt_err    <= timeout_c | bad_chk_c;
            // link_ok is sampled before any same-cycle commit
            Update_pat <= frame_tick & link_ok & ~expire_c;
            if (commit_c) begin
                vel_q       <= '{x_rsvd: 1'b0, x_mag: mx_c, y_rsvd: 1'b0, y_mag: my_c};
                direction_x <= ~sx_c;
                direction_y <= ~sy_c & (vy_q != '0);
                link_ok     <= 1'b1;
            end else if (expire_c) begin
                vel_q   <= '0;
                link_ok <= 1'b0;
            end
        end
    end

    assign pat_velocity = vel_q;

endmodule

// File: tb/tb_pat_velocity_rx.sv
// Self-checking bench for pat_velocity_rx: directed packet table, randomized
// packets against an arithmetic reference model, and hand-written sequences
// for update strobes, link loss, byte timeout and mid-packet reset.
module tb_pat_velocity_rx;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_tick;
    logic [31:0] pat_velocity;
    logic        direction_x;
    logic        direction_y;
    logic        Update_pat;
    logic        pkt_err;
    logic        link_ok;

    int n_checks = 0;
    int n_err    = 0;

    pat_velocity_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_tick   (frame_tick),
        .pat_velocity (pat_velocity),
        .direction_x  (direction_x),
        .direction_y  (direction_y),
        .Update_pat   (Update_pat),
        .pkt_err      (pkt_err),
        .link_ok      (link_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] pkt;
        logic [31:0] vel;
        logic        dx;
        logic        dy;
        logic        err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the signed value
    function automatic logic [15:0] model_mag(input logic [15:0] v);
        int s;
        s = $signed(v);
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        if (s < 8) s = 0;
        return 16'(s);
    endfunction

    // Called at a negedge; returns at the following negedge
    task automatic send_byte(input logic [7:0] b, input logic tick);
        rx_data    = b;
        rx_valid   = 1'b1;
        frame_tick = tick;
        @(negedge clk);
        rx_valid   = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic send_packet(input logic [47:0] p, input logic tick_on_chk, input int max_gap);
        logic [47:0] sh;
        sh = p;
        for (int k = 0; k < 6; k++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_byte(sh[47:40], (k == 5) ? tick_on_chk : 1'b0);
            sh = sh << 8;
        end
    endtask

    // Tick, then check the strobe the next cycle and its absence after
    task automatic tick_check(input string name, input logic exp_upd);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check({name, "_upd"}, 32'(Update_pat), 32'(exp_upd));
        @(negedge clk);
        check({name, "_upd_end"}, 32'(Update_pat), 32'd0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_vel"},  pat_velocity,       32'd0);
        check({name, "_dx"},   32'(direction_x),   32'd1);
        check({name, "_dy"},   32'(direction_y),   32'd0);
        check({name, "_upd"},  32'(Update_pat),    32'd0);
        check({name, "_err"},  32'(pkt_err),       32'd0);
        check({name, "_link"}, 32'(link_ok),       32'd0);
    endtask

    localparam logic [47:0] P1 = 48'hA5_01_20_FF_00_DE;
    localparam logic [47:0] P2 = 48'hA5_80_00_00_05_85;

    initial begin
        vec_t        vecs [6];
        logic [31:0] e_vel;
        logic        e_dx, e_dy;
        logic [15:0] vx, vy;
        logic [7:0]  ck, g;
        logic        bad, seen;
        int          at;

        vecs[0] = '{48'hA5_01_20_FF_00_DE, 32'h0120_0100, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{48'hA5_80_00_00_05_85, 32'h7FFF_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{48'hA5_01_20_FF_00_00, 32'h7FFF_0000, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{48'hA5_FF_FB_00_08_0C, 32'h0000_0008, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{48'hA5_7F_FF_00_00_80, 32'h7FFF_0000, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{48'hA5_A5_A5_00_10_10, 32'h5A5B_0010, 1'b0, 1'b1, 1'b0};

        rst_n      = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed packet table
        for (int i = 0; i < 6; i++) begin
            send_packet(vecs[i].pkt, 1'b0, 0);
            check($sformatf("vec%0d_vel", i),  pat_velocity,       vecs[i].vel);
            check($sformatf("vec%0d_dx", i),   32'(direction_x),   32'(vecs[i].dx));
            check($sformatf("vec%0d_dy", i),   32'(direction_y),   32'(vecs[i].dy));
            check($sformatf("vec%0d_err", i),  32'(pkt_err),       32'(vecs[i].err));
            check($sformatf("vec%0d_link", i), 32'(link_ok),       32'd1);
            @(negedge clk);
            check($sformatf("vec%0d_err_end", i), 32'(pkt_err), 32'd0);
        end

        // Randomized packets with idle garbage, gaps and corrupt checksums
        e_vel = 32'h5A5B_0010;
        e_dx  = 1'b0;
        e_dy  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 2; j++) begin
                case ($urandom_range(0, 3))
                    0:       vx = 16'($urandom_range(0, 16)) - 16'd8;
                    1:       vx = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
                    default: vx = 16'($urandom);
                endcase
                if (j == 0) vy = vx;
            end
            // vy picked above in the first pass; vx from the second
            ck  = vx[15:8] ^ vx[7:0] ^ vy[15:8] ^ vy[7:0];
            bad = ($urandom_range(0, 4) == 0);
            if (bad) ck = ck ^ 8'($urandom_range(1, 255));
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, 1'b0);
            end
            send_packet({8'hA5, vx, vy, ck}, 1'b0, 3);
            if (!bad) begin
                e_vel = {model_mag(vx), model_mag(vy)};
                e_dx  = ($signed(vx) >= 0);
                e_dy  = ($signed(vy) > 0);
            end
            check($sformatf("rnd%0d_vel", i), pat_velocity,     e_vel);
            check($sformatf("rnd%0d_dx", i),  32'(direction_x), 32'(e_dx));
            check($sformatf("rnd%0d_dy", i),  32'(direction_y), 32'(e_dy));
            check($sformatf("rnd%0d_err", i), 32'(pkt_err),     32'(bad));
        end

        // Fresh commit, then 9 quiet frames: link drops on the 8th
        send_packet(P1, 1'b0, 0);
        for (int t = 1; t <= 9; t++) begin
            tick_check($sformatf("age%0d", t), t < 8);
            check($sformatf("age%0d_link", t), 32'(link_ok), 32'(t < 8));
            check($sformatf("age%0d_vel", t), pat_velocity, (t < 8) ? 32'h0120_0100 : 32'd0);
        end
        check("lost_dx", 32'(direction_x), 32'd1);
        check("lost_dy", 32'(direction_y), 32'd0);

        // First good packet on a tick while link is down: no strobe
        send_packet(P2, 1'b1, 0);
        check("coin0_upd",  32'(Update_pat), 32'd0);
        check("coin0_link", 32'(link_ok),    32'd1);
        check("coin0_vel",  pat_velocity,    32'h7FFF_0000);
        // Good packet on a tick while link is up: strobe carries new value
        send_packet(P1, 1'b1, 0);
        check("coin1_upd", 32'(Update_pat), 32'd1);
        check("coin1_vel", pat_velocity,    32'h0120_0100);
        check("coin1_dx",  32'(direction_x), 32'd1);
        @(negedge clk);
        check("coin1_upd_end", 32'(Update_pat), 32'd0);

        // Byte timeout after A5 01
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < 50100; i++) begin
            @(negedge clk);
            if (pkt_err) begin
                seen = 1'b1;
                at   = i;
                break;
            end
        end
        check("timeout_seen", 32'(seen), 32'd1);
        check("timeout_window", 32'((at >= 49990) && (at <= 50010)), 32'd1);
        check("timeout_vel_hold", pat_velocity, 32'h0120_0100);
        @(negedge clk);
        check("timeout_err_end", 32'(pkt_err), 32'd0);
        send_packet(P2, 1'b0, 0);
        check("after_to_vel", pat_velocity,     32'h7FFF_0000);
        check("after_to_dx",  32'(direction_x), 32'd0);
        check("after_to_dy",  32'(direction_y), 32'd1);

        // Reset mid-packet discards the partial packet
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h20, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hDE, 1'b0);
        check("midrst_tail_vel",  pat_velocity, 32'd0);
        check("midrst_tail_link", 32'(link_ok), 32'd0);
        check("midrst_tail_err",  32'(pkt_err), 32'd0);
        send_packet(P1, 1'b0, 0);
        check("midrst_good_vel",  pat_velocity, 32'h0120_0100);
        check("midrst_good_link", 32'(link_ok), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
